// File: rtl/line_invert_stage_if.sv
// Bundles the live-statistics inputs, the one-line-delayed video inputs and
// the processed video outputs of line_invert_stage into one port group.
interface line_invert_stage_if;
    logic [1:0]  mode_i;
    logic [7:0]  thres_i;
    logic        de_i;
    logic [23:0] rgb_i;
    logic        dly_de_i;
    logic        dly_hs_i;
    logic        dly_vs_i;
    logic [23:0] dly_rgb_i;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;
    logic [23:0] rgb_o;
    logic        invert_o;

    modport master (
        output mode_i, thres_i, de_i, rgb_i,
        output dly_de_i, dly_hs_i, dly_vs_i, dly_rgb_i,
        input  de_o, hs_o, vs_o, rgb_o, invert_o
    );

    modport slave (
        input  mode_i, thres_i, de_i, rgb_i,
        input  dly_de_i, dly_hs_i, dly_vs_i, dly_rgb_i,
        output de_o, hs_o, vs_o, rgb_o, invert_o
    );
endinterface

// File: rtl/line_invert_stage.sv
// Per-line brightness statistics on the live stream decide whether the
// following (externally delayed) line is colour-inverted on output.
module line_invert_stage #(
    parameter int CW = 12,
    parameter int AW = CW + 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    line_invert_stage_if.slave bus
);
    localparam int PW = CW + 8;
    localparam int MW = (AW > PW) ? AW : PW;

    logic [9:0]    luma_sum;
    logic [7:0]    luma;

    logic          live_armed_q, live_armed_d;
    logic          live_prev_q, live_prev_d;
    logic          live_de, live_rise, live_fall;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW:0]   acc_sum;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] prod;
    logic [MW-1:0] acc_cmp, prod_cmp;
    logic          pending_q, pending_d;

    logic          dly_armed_q, dly_armed_d;
    logic          dly_prev_q, dly_prev_d;
    logic          dly_rise;
    logic          active_q, active_d;

    logic [23:0]   rgb_d;
    logic          de_q, hs_q, vs_q, invert_q;
    logic [23:0]   rgb_q;

    assign luma_sum = {2'b00, bus.rgb_i[23:16]} + {1'b0, bus.rgb_i[15:8], 1'b0}
                    + {2'b00, bus.rgb_i[7:0]};
    assign luma     = luma_sum[9:2];

    // Edges are only recognised once the signal has been seen low after reset,
    // so a line already in progress at reset release is ignored entirely.
    assign live_de   = bus.de_i & live_armed_q;
    assign live_rise = live_de & ~live_prev_q;
    assign live_fall = ~live_de & live_prev_q;

    assign acc_sum  = {1'b0, acc_q} + {{(AW + 1 - 8){1'b0}}, luma};
    assign prod     = {{CW{1'b0}}, bus.thres_i} * {8'b0, cnt_q};
    assign acc_cmp  = {{(MW - AW){1'b0}}, acc_q};
    assign prod_cmp = {{(MW - PW){1'b0}}, prod};

    always_comb begin
        live_armed_d = live_armed_q | ~bus.de_i;
        live_prev_d  = live_de;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        if (live_rise) begin
            acc_d = {{(AW - 8){1'b0}}, luma};
            cnt_d = {{(CW - 1){1'b0}}, 1'b1};
        end else if (live_de) begin
            acc_d = acc_sum[AW] ? {AW{1'b1}} : acc_sum[AW-1:0];
            if (!(&cnt_q))
                cnt_d = cnt_q + 1'b1;
        end
        if (live_fall)
            pending_d = (acc_cmp > prod_cmp);
    end

    assign dly_rise = bus.dly_de_i & dly_armed_q & ~dly_prev_q;

    // active_d is the flag in effect for the current delayed pixel, so the
    // first pixel of a line already sees the freshly loaded decision.
    always_comb begin
        dly_armed_d = dly_armed_q | ~bus.dly_de_i;
        dly_prev_d  = bus.dly_de_i & dly_armed_q;
        active_d    = active_q;
        if (dly_rise) begin
            case (bus.mode_i)
                2'b01:   active_d = 1'b1;
                2'b10:   active_d = pending_q;
                default: active_d = 1'b0;
            endcase
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign rgb_d[gi*8 +: 8] = bus.dly_de_i ? (bus.dly_rgb_i[gi*8 +: 8] ^ {8{active_d}})
                                               : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live_armed_q <= 1'b0;
            live_prev_q  <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            dly_armed_q  <= 1'b0;
            dly_prev_q   <= 1'b0;
            active_q     <= 1'b0;
            de_q         <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            rgb_q        <= '0;
            invert_q     <= 1'b0;
        end else begin
            live_armed_q <= live_armed_d;
            live_prev_q  <= live_prev_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            dly_armed_q  <= dly_armed_d;
            dly_prev_q   <= dly_prev_d;
            active_q     <= active_d;
            de_q         <= bus.dly_de_i;
            hs_q         <= bus.dly_hs_i;
            vs_q         <= bus.dly_vs_i;
            rgb_q        <= rgb_d;
            invert_q     <= active_d;
        end
    end

    assign bus.de_o     = de_q;
    assign bus.hs_o     = hs_q;
    assign bus.vs_o     = vs_q;
    assign bus.rgb_o    = rgb_q;
    assign bus.invert_o = invert_q;
endmodule

// File: tb/tb_line_invert_stage.sv
// Directed bench for line_invert_stage: the bench plays both the live stream
// and the one-line-delayed stream and checks the processed output lines.
module tb_line_invert_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    line_invert_stage_if bus ();

    line_invert_stage #(.CW(12), .AW(20)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; after the next falling edge the
    // registered outputs belong to exactly these inputs.
    task automatic cyc(input logic lde, input logic [23:0] lrgb, input logic dde,
                       input logic [23:0] drgb, input logic hs, input logic vs);
        bus.de_i      = lde;
        bus.rgb_i     = lrgb;
        bus.dly_de_i  = dde;
        bus.dly_rgb_i = drgb;
        bus.dly_hs_i  = hs;
        bus.dly_vs_i  = vs;
        @(negedge clk);
    endtask

    task automatic run_line(input int n, input logic lde, input logic [23:0] lrgb,
                            input logic dde, input logic [23:0] drgb,
                            input int sw_at, input logic [1:0] sw_mode,
                            output logic [23:0] first_rgb, output logic first_inv,
                            output logic uniform);
        first_rgb = '0;
        first_inv = 1'b0;
        uniform   = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == sw_at) bus.mode_i = sw_mode;
            cyc(lde, lrgb, dde, drgb, 1'b0, 1'b0);
            if (i == 0) begin
                first_rgb = bus.rgb_o;
                first_inv = bus.invert_o;
            end else if (bus.rgb_o !== first_rgb || bus.invert_o !== first_inv) begin
                uniform = 1'b0;
            end
        end
        repeat (4) cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode_i  = 2'b01;
        bus.thres_i = 8'd0;
        repeat (3) cyc(1'b1, 24'hFFFFFF, 1'b1, 24'h123456, 1'b1, 1'b1);
        total++;
        if ({bus.de_o, bus.hs_o, bus.vs_o, bus.invert_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {bus.de_o, bus.hs_o, bus.vs_o, bus.invert_o});
        end
        total++;
        if (bus.rgb_o !== 24'h0) begin
            bad++;
            $display("FAIL reset_rgb got=%h want=000000", bus.rgb_o);
        end
        rst = 1'b0;
        repeat (3) cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        total++;
        if (bus.de_o !== 1'b0 || bus.rgb_o !== 24'h0) begin
            bad++;
            $display("FAIL idle_after_reset de=%b rgb=%h want de=0 rgb=000000", bus.de_o, bus.rgb_o);
        end
    endtask

    task automatic test_auto_bright();
        logic [23:0] f;
        logic        inv, uni;
        bus.mode_i  = 2'b10;
        bus.thres_i = 8'd128;
        run_line(640, 1'b1, 24'hFFFFFF, 1'b1, 24'h000000, -1, 2'b10, f, inv, uni);
        run_line(640, 1'b1, 24'h000000, 1'b1, 24'hFFFFFF, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'h000000 || inv !== 1'b1 || uni !== 1'b1) begin
            bad++;
            $display("FAIL auto_bright got rgb=%h inv=%b uni=%b want rgb=000000 inv=1 uni=1", f, inv, uni);
        end
    endtask

    task automatic test_threshold();
        logic [23:0] f;
        logic        inv, uni;
        bus.mode_i  = 2'b10;
        bus.thres_i = 8'd128;
        run_line(640, 1'b1, 24'h7F7F7F, 1'b1, 24'h555555, -1, 2'b10, f, inv, uni);
        run_line(640, 1'b1, 24'h808080, 1'b1, 24'h7F7F7F, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'h7F7F7F || inv !== 1'b0 || uni !== 1'b1) begin
            bad++;
            $display("FAIL thres_luma127 got rgb=%h inv=%b want rgb=7f7f7f inv=0", f, inv);
        end
        run_line(640, 1'b1, 24'h818181, 1'b1, 24'h808080, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'h808080 || inv !== 1'b0 || uni !== 1'b1) begin
            bad++;
            $display("FAIL thres_luma128_strict got rgb=%h inv=%b want rgb=808080 inv=0", f, inv);
        end
        run_line(640, 1'b1, 24'h000000, 1'b1, 24'h818181, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'h7E7E7E || inv !== 1'b1 || uni !== 1'b1) begin
            bad++;
            $display("FAIL thres_luma129 got rgb=%h inv=%b want rgb=7e7e7e inv=1", f, inv);
        end
    endtask

    task automatic test_modes();
        logic [23:0] f;
        logic        inv, uni;
        bus.mode_i = 2'b01;
        run_line(32, 1'b1, 24'h101010, 1'b1, 24'h101010, -1, 2'b01, f, inv, uni);
        total++;
        if (f !== 24'hEFEFEF || inv !== 1'b1 || uni !== 1'b1) begin
            bad++;
            $display("FAIL mode_force got rgb=%h inv=%b want rgb=efefef inv=1", f, inv);
        end
        bus.mode_i = 2'b00;
        run_line(32, 1'b1, 24'hFFFFFF, 1'b1, 24'h101010, -1, 2'b00, f, inv, uni);
        total++;
        if (f !== 24'h101010 || inv !== 1'b0 || uni !== 1'b1) begin
            bad++;
            $display("FAIL mode_pass got rgb=%h inv=%b want rgb=101010 inv=0", f, inv);
        end
        bus.mode_i = 2'b11;
        run_line(32, 1'b1, 24'hFFFFFF, 1'b1, 24'h101010, -1, 2'b11, f, inv, uni);
        total++;
        if (f !== 24'h101010 || inv !== 1'b0) begin
            bad++;
            $display("FAIL mode_11 got rgb=%h inv=%b want rgb=101010 inv=0", f, inv);
        end
        bus.mode_i = 2'b00;
        run_line(32, 1'b1, 24'h101010, 1'b1, 24'h101010, 10, 2'b01, f, inv, uni);
        total++;
        if (f !== 24'h101010 || inv !== 1'b0 || uni !== 1'b1) begin
            bad++;
            $display("FAIL mode_midline got rgb=%h inv=%b uni=%b want rgb=101010 inv=0 uni=1", f, inv, uni);
        end
        run_line(32, 1'b1, 24'h101010, 1'b1, 24'h101010, -1, 2'b01, f, inv, uni);
        total++;
        if (f !== 24'hEFEFEF || inv !== 1'b1 || uni !== 1'b1) begin
            bad++;
            $display("FAIL mode_nextline got rgb=%h inv=%b want rgb=efefef inv=1", f, inv);
        end
    endtask

    task automatic test_coincide();
        logic [23:0] f;
        logic        inv, uni;
        bus.mode_i  = 2'b10;
        bus.thres_i = 8'd128;
        run_line(8, 1'b1, 24'hFFFFFF, 1'b0, 24'h0, -1, 2'b10, f, inv, uni);
        repeat (8) cyc(1'b1, 24'h000000, 1'b0, 24'h0, 1'b0, 1'b0);
        // live line falls on the very cycle the delayed line starts
        cyc(1'b0, 24'h0, 1'b1, 24'h202020, 1'b0, 1'b0);
        total++;
        if (bus.rgb_o !== 24'hDFDFDF || bus.invert_o !== 1'b1) begin
            bad++;
            $display("FAIL coincide_first got rgb=%h inv=%b want rgb=dfdfdf inv=1", bus.rgb_o, bus.invert_o);
        end
        repeat (3) cyc(1'b0, 24'h0, 1'b1, 24'h202020, 1'b0, 1'b0);
        total++;
        if (bus.rgb_o !== 24'hDFDFDF) begin
            bad++;
            $display("FAIL coincide_hold got rgb=%h want rgb=dfdfdf", bus.rgb_o);
        end
        repeat (4) cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        run_line(8, 1'b0, 24'h0, 1'b1, 24'h202020, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'h202020 || inv !== 1'b0) begin
            bad++;
            $display("FAIL coincide_next got rgb=%h inv=%b want rgb=202020 inv=0", f, inv);
        end
    endtask

    task automatic test_reset_midline();
        logic [23:0] f;
        logic        inv, uni;
        bus.mode_i  = 2'b10;
        bus.thres_i = 8'd0;
        run_line(20, 1'b1, 24'h404040, 1'b0, 24'h0, -1, 2'b10, f, inv, uni);
        repeat (10) cyc(1'b1, 24'h404040, 1'b1, 24'hAAAAAA, 1'b1, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 24'h404040, 1'b1, 24'hAAAAAA, 1'b1, 1'b1);
            total++;
            if ({bus.de_o, bus.hs_o, bus.vs_o, bus.invert_o} !== 4'b0000 || bus.rgb_o !== 24'h0) begin
                bad++;
                $display("FAIL midreset_%0d got ctrl=%b rgb=%h want 0000 000000", i,
                         {bus.de_o, bus.hs_o, bus.vs_o, bus.invert_o}, bus.rgb_o);
            end
        end
        rst = 1'b0;
        repeat (5) cyc(1'b1, 24'h404040, 1'b1, 24'hAAAAAA, 1'b0, 1'b0);
        total++;
        if (bus.rgb_o !== 24'hAAAAAA || bus.invert_o !== 1'b0 || bus.de_o !== 1'b1) begin
            bad++;
            $display("FAIL partial_after_reset got rgb=%h inv=%b de=%b want aaaaaa 0 1", bus.rgb_o, bus.invert_o, bus.de_o);
        end
        repeat (4) cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        run_line(16, 1'b1, 24'h000000, 1'b1, 24'hFFFFFF, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'hFFFFFF || inv !== 1'b0 || uni !== 1'b1) begin
            bad++;
            $display("FAIL first_line_after_reset got rgb=%h inv=%b want ffffff 0", f, inv);
        end
    endtask

    task automatic test_pulse();
        logic [23:0] f;
        logic        inv, uni;
        bus.mode_i = 2'b00;
        cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0);
        cyc(1'b0, 24'h0, 1'b1, 24'hABCDEF, 1'b1, 1'b1);
        total++;
        if ({bus.de_o, bus.hs_o, bus.vs_o} !== 3'b111 || bus.rgb_o !== 24'hABCDEF) begin
            bad++;
            $display("FAIL pulse_on got ctrl=%b rgb=%h want 111 abcdef", {bus.de_o, bus.hs_o, bus.vs_o}, bus.rgb_o);
        end
        cyc(1'b0, 24'h0, 1'b0, 24'hABCDEF, 1'b0, 1'b0);
        total++;
        if ({bus.de_o, bus.hs_o, bus.vs_o} !== 3'b000 || bus.rgb_o !== 24'h0) begin
            bad++;
            $display("FAIL pulse_off got ctrl=%b rgb=%h want 000 000000", {bus.de_o, bus.hs_o, bus.vs_o}, bus.rgb_o);
        end
        bus.mode_i  = 2'b10;
        bus.thres_i = 8'd128;
        run_line(1, 1'b1, 24'hFFFFFF, 1'b0, 24'h0, -1, 2'b10, f, inv, uni);
        run_line(4, 1'b0, 24'h0, 1'b1, 24'h0F0F0F, -1, 2'b10, f, inv, uni);
        total++;
        if (f !== 24'hF0F0F0 || inv !== 1'b1 || uni !== 1'b1) begin
            bad++;
            $display("FAIL one_pixel_line got rgb=%h inv=%b want f0f0f0 1", f, inv);
        end
    endtask

    initial begin
        bus.mode_i    = 2'b00;
        bus.thres_i   = 8'd0;
        bus.de_i      = 1'b0;
        bus.rgb_i     = '0;
        bus.dly_de_i  = 1'b0;
        bus.dly_hs_i  = 1'b0;
        bus.dly_vs_i  = 1'b0;
        bus.dly_rgb_i = '0;
        @(negedge clk);
        test_reset();
        test_auto_bright();
        test_threshold();
        test_modes();
        test_coincide();
        test_reset_midline();
        test_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_invert_stage.md
LINE_INVERT_STAGE -- requirements
Module: line_invert_stage

Interface
REQ-001 SHALL have parameter CW, default 12: pixel-counter width; supports lines up to 2^CW-1 active pixels.
REQ-002 SHALL have parameter AW, default CW+8: luma-accumulator width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mode_i  input  2  00 pass-through, 01 force invert, 10 auto, 11 treated as 00.
REQ-006 SHALL have port thres_i  input  8  auto-mode brightness threshold, sampled at live line end.
REQ-007 SHALL have port de_i  input  1  live data-enable; feeds statistics only.
REQ-008 SHALL have port rgb_i  input  24  live pixel {R,G,B}, valid when de_i=1.
REQ-009 SHALL have port dly_de_i / dly_hs_i / dly_vs_i  input  1 each  timing, delayed by exactly one line by an external delay line.
REQ-010 SHALL have port dly_rgb_i  input  24  pixel from the same external delay line.
REQ-011 SHALL have port de_o / hs_o / vs_o  output  1 each  registered copies of dly_de_i / dly_hs_i / dly_vs_i.
REQ-012 SHALL have port rgb_o  output  24  processed pixel.
REQ-013 SHALL have port invert_o  output  1  active per-line invert flag applied to the current output line.

Function
REQ-014 SHALL compute luma per live pixel as (R + 2*G + B) >> 2, 8 bits, no rounding.
REQ-015 SHALL, on each cycle with de_i=1, add luma to acc (AW bits) and increment cnt (CW bits); cnt saturates at 2^CW-1, acc saturates at all-ones.
REQ-016 SHALL, on de_i rising edge (de_i=1, prev de_i=0), load acc=luma and cnt=1, discarding previous values.
REQ-017 SHALL, on de_i falling edge (de_i=0, prev de_i=1), set pending = (acc > thres_i * cnt), product computed full-width CW+8 bits, strict greater-than.
REQ-018 SHALL, on dly_de_i rising edge, load active flag: mode 01 -> 1; mode 00/11 -> 0; mode 10 -> pending.
REQ-019 SHALL hold active constant while dly_de_i=1; mode_i changes mid-line take effect at the next dly_de_i rising edge only.
REQ-020 SHALL, when live de_i falls in the same cycle dly_de_i rises, load active from the old pending value; pending updates concurrently.
REQ-021 SHALL produce rgb_o = dly_rgb_i ^ 24'hFFFFFF when dly_de_i=1 and active flag (the value in effect for that pixel) =1; else dly_rgb_i; rgb_o forced 0 when dly_de_i=0.
REQ-022 SHALL have latency exactly 1 cycle from dly_* inputs to de_o/hs_o/vs_o/rgb_o, all registered, mutually aligned.
REQ-023 SHALL drive invert_o as the registered active flag aligned with rgb_o of the first pixel of each line.
REQ-024 SHALL treat a one-pixel line (de_i high one cycle) as valid: cnt=1, acc=luma.
REQ-025 SHALL not use hs/vs for statistics; frame boundaries need no special handling.

Reset
REQ-026 SHALL, while rst_i=1, clear acc, cnt, pending, active, prev-de registers, and drive de_o=hs_o=vs_o=0, rgb_o=0, invert_o=0.
REQ-027 SHALL, on reset released mid-line (de_i or dly_de_i already 1), ignore that partial line: no edge is detected until the signal goes low then high; first output line uses active=0 in mode 10.

Verification
REQ-028 Bench SHALL cover: mode 10, thres 128, live line of 640 pixels rgb=FFFFFF -> next delayed line rgb_o=000000, invert_o=1.
REQ-029 Bench SHALL cover: mode 10, thres 128, live line of 640 pixels rgb=7F7F7F (luma 127) -> pending=0, delayed line rgb_o=7F7F7F; luma 128 line (808080) -> also pending=0 (strict compare); 818181 -> pending=1.
REQ-030 Bench SHALL cover: mode 01 with dark input 101010 -> rgb_o=EFEFEF; mode 00 -> rgb_o=101010; mode switched mid-line -> change visible only from next line.
REQ-031 Bench SHALL cover: live de_i fall coinciding with dly_de_i rise -> delayed line uses previous line's decision.
REQ-032 Bench SHALL cover: rst_i asserted 3 cycles mid-line -> all outputs 0 during reset; first full line after reset output unmodified in mode 10.
REQ-033 Bench SHALL cover: 1-cycle dly_* pulse -> de_o/hs_o/vs_o/rgb_o pulse exactly one cycle later, width preserved.
